iq_pair_fifo: RTL and testbench
===============================

Name: iq_pair_fifo

Overview:
- Sits directly downstream of the I/Q window-select stage: captures its independently strobed 32-bit I and Q words, pairs them, and buffers pairs in a small FIFO.
- Presents pairs on a valid/ready interface to the MCU-side readout logic.
- Decouples bursty decimator output timing from MCU read timing.
- Flags lost pairs and I/Q desynchronisation.

Parameters:
- DATA_WIDTH, 32, width of each I and Q word.
- DEPTH, 16, FIFO depth in pairs; must be a power of two, ≥4.
- ADDR_W, 4, log2(DEPTH).

Ports:
- clk_in  input  1  system clock; all logic on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- in_I  input  DATA_WIDTH  I word from upstream stage.
- in_valid_I  input  1  I strobe, level, synchronous to clk_in.
- in_Q  input  DATA_WIDTH  Q word from upstream stage.
- in_valid_Q  input  1  Q strobe, level, synchronous to clk_in.
- enabled  input  1  block enable; low flushes and idles.
- out_I  output  DATA_WIDTH  head-of-FIFO I word.
- out_Q  output  DATA_WIDTH  head-of-FIFO Q word.
- out_valid  output  1  head pair valid.
- out_ready  input  1  consumer accepts pair when out_valid & out_ready.
- fill_level  output  ADDR_W+1  pairs currently stored, 0..DEPTH.
- overflow  output  1  sticky: a pair was dropped because the FIFO was full.
- desync  output  1  sticky: same-channel word arrived twice before its partner.
- clear_flags  input  1  synchronous clear of overflow and desync (and drop counter).
- dropped_pairs  output  16  drop counter (see Optional Feature).

Behaviour:
- Reset (reset_n low, asynchronous):
  - Pointers, fill_level, overflow, desync and dropped_pairs are 0.
  - out_I, out_Q and out_valid are 0.
  - Pairing state is IDLE.
- Strobe capture:
  - Each strobe is registered once (prev_*).
  - A capture event occurs in cycle N when in_valid_x=1 and prev_x=0; in_x is sampled in that same cycle.
  - Upstream holds data stable from the strobe rise for ≥1 clk.
- Pairing FSM:
  - IDLE:
    - I event only: latch I, go HAVE_I.
    - Q event only: latch Q, go HAVE_Q.
    - Both in the same cycle: push pair, stay IDLE.
  - HAVE_I:
    - Q event: push (held I, new Q), go IDLE.
    - I event, no Q: replace held I, set desync, stay.
    - I and Q events together: push (new I, new Q), set desync, go IDLE.
  - HAVE_Q: mirror of HAVE_I.
- Push:
  - Writes the pair at the clk edge ending cycle N.
  - If the FIFO is full and no pop occurs in cycle N: pair dropped, overflow set, dropped_pairs incremented.
  - If the FIFO is full and a pop occurs in the same cycle: push accepted and fill_level unchanged.
- Output:
  - Registered show-ahead. out_I, out_Q and out_valid reflect the head entry.
  - Empty FIFO, push completes in cycle N: out_valid=1 from cycle N+2.
  - Pop on out_valid & out_ready. The next entry, if any, is presented the following cycle, giving back-to-back throughput of 1 pair/clk.
  - out_I and out_Q are held unchanged while out_valid=1 and out_ready=0.
  - When empty: out_valid=0, and out_I/out_Q keep their last value.
- Pointers: ADDR_W-bit, wrapping modulo DEPTH. fill_level counts 0..DEPTH with no wrap.
- enabled low:
  - Synchronously empties the FIFO (pointers and fill_level to 0).
  - Forces out_valid=0 and out_I/out_Q=0, and sets the FSM to IDLE.
  - Ignores strobes; prev_* is still tracked so no false edge occurs when re-enabled.
  - Sticky flags are retained.
- clear_flags:
  - Clears overflow, desync and dropped_pairs.
  - If it coincides with a setting event, the set wins.
- Reset mid-operation: all state is lost immediately; no partial pair survives.

Optional Feature:
- Macro IQ_PAIR_STATS_EN.
- Defined:
  - dropped_pairs is a 16-bit saturating counter (stops at 65535) of dropped pairs.
  - Cleared by reset or clear_flags.
- Undefined: dropped_pairs is tied to 0. The port remains present so the interface is unchanged.

Test Plan:
- Basic pairing: I strobe (I=0x11111111) in cycle 0, Q strobe (Q=0x22222222) in cycle 3, out_ready=1 → out_valid=1 at cycle 5 for one cycle with out_I=0x11111111, out_Q=0x22222222; fill_level returns to 0.
- Simultaneous strobes: I and Q rise in the same cycle, 20 times, with out_ready=0 → 16 pairs stored, fill_level=16, 4 drops, overflow=1, dropped_pairs=4 with IQ_PAIR_STATS_EN (0 without).
- Full plus pop: with the FIFO full and out_ready=1, a pair completes in the same cycle as a pop → push accepted, fill_level stays 16, overflow unchanged.
- Desync: I=0xA, then I=0xB, then Q=0xC → desync=1, the single pair output is (0xB, 0xC); clear_flags pulse → desync=0.
- Backpressure and wrap: push 40 pairs with incrementing data while toggling out_ready randomly → all 40 pairs read in order with no duplicates, and pointers wrap correctly.
- Disable and reset: enabled=0 with 5 pairs stored → out_valid=0 and fill_level=0 the next cycle. Re-enable with strobes held high → no capture. Assert reset_n low mid-burst → all outputs 0 immediately.

Source files
------------

// File: rtl/iq_pair_fifo.sv
// I/Q pairing stage with a show-ahead pair FIFO between the window-select stage and MCU readout.
// Optional drop statistics are enabled with the IQ_PAIR_STATS_EN macro.
module iq_pair_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int ADDR_W     = 4
) (
  input  logic                  clk_in,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] in_I,
  input  logic                  in_valid_I,
  input  logic [DATA_WIDTH-1:0] in_Q,
  input  logic                  in_valid_Q,
  input  logic                  enabled,
  output logic [DATA_WIDTH-1:0] out_I,
  output logic [DATA_WIDTH-1:0] out_Q,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_W:0]       fill_level,
  output logic                  overflow,
  output logic                  desync,
  input  logic                  clear_flags,
  output logic [15:0]           dropped_pairs
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HAVE_I = 2'd1,
    ST_HAVE_Q = 2'd2
  } state_t;

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  logic                    prev_i_r, prev_q_r;
  logic                    ev_i_s, ev_q_s;
  state_t                  state_r, state_nxt_s;
  logic [DATA_WIDTH-1:0]   hold_i_r, hold_q_r;
  logic                    push_s, desync_set_s, latch_i_s, latch_q_s;
  logic [DATA_WIDTH-1:0]   push_i_s, push_q_s;
  logic [2*DATA_WIDTH-1:0] mem_r [DEPTH];
  logic [ADDR_W-1:0]       wr_ptr_r, rd_ptr_r, rd_nxt_s;
  logic [ADDR_W:0]         count_r, cnt_after_pop_s;
  logic                    pop_s, full_s, drop_s, wr_en_s;
  logic                    out_valid_r, overflow_r, desync_r;
  logic [DATA_WIDTH-1:0]   out_i_r, out_q_r;

  // Strobes are tracked even while disabled so re-enabling never produces a false edge
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      prev_i_r <= 1'b0;
      prev_q_r <= 1'b0;
    end else begin
      prev_i_r <= in_valid_I;
      prev_q_r <= in_valid_Q;
    end
  end

  assign ev_i_s = enabled & in_valid_I & ~prev_i_r;
  assign ev_q_s = enabled & in_valid_Q & ~prev_q_r;

  // Pairing state register
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else if (!enabled) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Pairing next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (ev_i_s && ev_q_s) state_nxt_s = ST_IDLE;
        else if (ev_i_s)      state_nxt_s = ST_HAVE_I;
        else if (ev_q_s)      state_nxt_s = ST_HAVE_Q;
        else                  state_nxt_s = ST_IDLE;
      end
      ST_HAVE_I: begin
        if (ev_q_s) state_nxt_s = ST_IDLE;
        else        state_nxt_s = ST_HAVE_I;
      end
      ST_HAVE_Q: begin
        if (ev_i_s) state_nxt_s = ST_IDLE;
        else        state_nxt_s = ST_HAVE_Q;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Pairing outputs: push request, pair contents, word latching and desync detection
  always_comb begin
    push_s       = 1'b0;
    push_i_s     = in_I;
    push_q_s     = in_Q;
    desync_set_s = 1'b0;
    latch_i_s    = 1'b0;
    latch_q_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (ev_i_s && ev_q_s) begin
          push_s = 1'b1;
        end else if (ev_i_s) begin
          latch_i_s = 1'b1;
        end else if (ev_q_s) begin
          latch_q_s = 1'b1;
        end else begin
          push_s = 1'b0;
        end
      end
      ST_HAVE_I: begin
        if (ev_i_s && ev_q_s) begin
          push_s       = 1'b1;
          desync_set_s = 1'b1;
        end else if (ev_q_s) begin
          push_s   = 1'b1;
          push_i_s = hold_i_r;
        end else if (ev_i_s) begin
          latch_i_s    = 1'b1;
          desync_set_s = 1'b1;
        end else begin
          push_s = 1'b0;
        end
      end
      ST_HAVE_Q: begin
        if (ev_i_s && ev_q_s) begin
          push_s       = 1'b1;
          desync_set_s = 1'b1;
        end else if (ev_i_s) begin
          push_s   = 1'b1;
          push_q_s = hold_q_r;
        end else if (ev_q_s) begin
          latch_q_s    = 1'b1;
          desync_set_s = 1'b1;
        end else begin
          push_s = 1'b0;
        end
      end
      default: push_s = 1'b0;
    endcase
  end

  // Holding registers for a half-received pair
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      hold_i_r <= {DATA_WIDTH{1'b0}};
      hold_q_r <= {DATA_WIDTH{1'b0}};
    end else begin
      if (latch_i_s) hold_i_r <= in_I;
      if (latch_q_s) hold_q_r <= in_Q;
    end
  end

  // A pop frees the slot in the same cycle, so a full FIFO still accepts a coincident push
  assign pop_s           = out_valid_r & out_ready;
  assign full_s          = (count_r == FULL_CNT);
  assign wr_en_s         = push_s & (~full_s | pop_s);
  assign drop_s          = push_s & full_s & ~pop_s;
  assign rd_nxt_s        = rd_ptr_r + (ADDR_W)'(pop_s);
  assign cnt_after_pop_s = count_r - (ADDR_W+1)'(pop_s);

  // Pair storage
  always_ff @(posedge clk_in) begin
    if (wr_en_s) mem_r[wr_ptr_r] <= {push_i_s, push_q_s};
  end

  // Pointers and occupancy
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r <= {ADDR_W{1'b0}};
      rd_ptr_r <= {ADDR_W{1'b0}};
      count_r  <= {(ADDR_W+1){1'b0}};
    end else if (!enabled) begin
      wr_ptr_r <= {ADDR_W{1'b0}};
      rd_ptr_r <= {ADDR_W{1'b0}};
      count_r  <= {(ADDR_W+1){1'b0}};
    end else begin
      if (wr_en_s) wr_ptr_r <= wr_ptr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
      rd_ptr_r <= rd_nxt_s;
      count_r  <= count_r + (ADDR_W+1)'(wr_en_s) - (ADDR_W+1)'(pop_s);
    end
  end

  // Show-ahead head register; only entries already stored at the start of the cycle are presented
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_r <= 1'b0;
      out_i_r     <= {DATA_WIDTH{1'b0}};
      out_q_r     <= {DATA_WIDTH{1'b0}};
    end else if (!enabled) begin
      out_valid_r <= 1'b0;
      out_i_r     <= {DATA_WIDTH{1'b0}};
      out_q_r     <= {DATA_WIDTH{1'b0}};
    end else if (cnt_after_pop_s != {(ADDR_W+1){1'b0}}) begin
      out_valid_r        <= 1'b1;
      {out_i_r, out_q_r} <= mem_r[rd_nxt_s];
    end else begin
      out_valid_r <= 1'b0;
    end
  end

  // Sticky error flags; a coincident set beats clear_flags
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      overflow_r <= 1'b0;
      desync_r   <= 1'b0;
    end else begin
      if (drop_s)           overflow_r <= 1'b1;
      else if (clear_flags) overflow_r <= 1'b0;
      if (desync_set_s)     desync_r <= 1'b1;
      else if (clear_flags) desync_r <= 1'b0;
    end
  end

`ifdef IQ_PAIR_STATS_EN
  logic [15:0] dropped_r;

  // Saturating drop counter; a drop coinciding with clear_flags counts as the first new drop
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      dropped_r <= 16'd0;
    end else if (drop_s) begin
      if (clear_flags)               dropped_r <= 16'd1;
      else if (dropped_r != 16'hFFFF) dropped_r <= dropped_r + 16'd1;
      else                           dropped_r <= dropped_r;
    end else if (clear_flags) begin
      dropped_r <= 16'd0;
    end else begin
      dropped_r <= dropped_r;
    end
  end

  assign dropped_pairs = dropped_r;
`else
  assign dropped_pairs = 16'd0;
`endif

  assign out_I      = out_i_r;
  assign out_Q      = out_q_r;
  assign out_valid  = out_valid_r;
  assign fill_level = count_r;
  assign overflow   = overflow_r;
  assign desync     = desync_r;

endmodule

// File: tb/tb_iq_pair_fifo.sv
// Directed self-checking bench for iq_pair_fifo with a pair scoreboard.
module tb_iq_pair_fifo;

  logic        clk_in, reset_n, enabled, out_ready, clear_flags;
  logic [31:0] in_I, in_Q, out_I, out_Q;
  logic        in_valid_I, in_valid_Q, out_valid, overflow, desync;
  logic [4:0]  fill_level;
  logic [15:0] dropped_pairs;

  logic [63:0] sb[$];
  int          n_tests, n_fail;

`ifdef IQ_PAIR_STATS_EN
  localparam logic [15:0] EXP_DROPS = 16'd4;
`else
  localparam logic [15:0] EXP_DROPS = 16'd0;
`endif

  iq_pair_fifo #(.DATA_WIDTH(32), .DEPTH(16), .ADDR_W(4)) dut (
    .clk_in(clk_in), .reset_n(reset_n),
    .in_I(in_I), .in_valid_I(in_valid_I), .in_Q(in_Q), .in_valid_Q(in_valid_Q),
    .enabled(enabled), .out_I(out_I), .out_Q(out_Q), .out_valid(out_valid),
    .out_ready(out_ready), .fill_level(fill_level), .overflow(overflow),
    .desync(desync), .clear_flags(clear_flags), .dropped_pairs(dropped_pairs)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; any handshake at the coming edge is checked against the scoreboard
  task automatic tick();
    logic [63:0] exp;
    @(negedge clk_in);
    if (out_valid && out_ready) begin
      if (sb.size() == 0) exp = 64'hDEAD_BEEF_DEAD_BEEF;
      else                exp = sb.pop_front();
      chk("pair", {out_I, out_Q}, exp);
    end
    @(posedge clk_in);
    #1;
  endtask

  initial begin
    clk_in = 1'b0; reset_n = 1'b0; enabled = 1'b0; out_ready = 1'b0; clear_flags = 1'b0;
    in_I = 32'd0; in_Q = 32'd0; in_valid_I = 1'b0; in_valid_Q = 1'b0;
    n_tests = 0; n_fail = 0;

    #12;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_fill", 64'(fill_level), 64'd0);
    chk("rst_data", {out_I, out_Q}, 64'd0);
    chk("rst_flags", {62'd0, overflow, desync}, 64'd0);
    chk("rst_drops", 64'(dropped_pairs), 64'd0);
    @(posedge clk_in); #1;
    reset_n = 1'b1; enabled = 1'b1; out_ready = 1'b1;
    tick(); tick();

    // Basic pairing: I in cycle 0, Q in cycle 3, head valid in cycle 5
    in_I = 32'h1111_1111; in_valid_I = 1'b1; tick();
    in_valid_I = 1'b0; tick(); tick();
    in_Q = 32'h2222_2222; in_valid_Q = 1'b1; sb.push_back({32'h1111_1111, 32'h2222_2222}); tick();
    in_valid_Q = 1'b0;
    chk("basic_c4_valid", 64'(out_valid), 64'd0);
    chk("basic_c4_fill", 64'(fill_level), 64'd1);
    tick();
    chk("basic_c5_valid", 64'(out_valid), 64'd1);
    chk("basic_c5_data", {out_I, out_Q}, {32'h1111_1111, 32'h2222_2222});
    tick();
    chk("basic_c6_valid", 64'(out_valid), 64'd0);
    chk("basic_c6_fill", 64'(fill_level), 64'd0);

    // Simultaneous strobes into a stalled FIFO: 16 stored, 4 dropped
    out_ready = 1'b0;
    for (int k = 0; k < 20; k++) begin
      in_I = 32'hA000_0000 + 32'(k); in_Q = 32'hB000_0000 + 32'(k);
      in_valid_I = 1'b1; in_valid_Q = 1'b1;
      if (k < 16) sb.push_back({in_I, in_Q});
      tick();
      in_valid_I = 1'b0; in_valid_Q = 1'b0;
      tick();
    end
    tick(); tick();
    chk("full_fill", 64'(fill_level), 64'd16);
    chk("full_overflow", 64'(overflow), 64'd1);
    chk("full_drops", 64'(dropped_pairs), 64'(EXP_DROPS));
    chk("full_head", {out_I, out_Q}, {32'hA000_0000, 32'hB000_0000});

    clear_flags = 1'b1; tick(); clear_flags = 1'b0;
    chk("clr_overflow", 64'(overflow), 64'd0);
    chk("clr_drops", 64'(dropped_pairs), 64'd0);

    // Push coinciding with a pop while full
    in_I = 32'hC000_0001; in_Q = 32'hD000_0001; in_valid_I = 1'b1; in_valid_Q = 1'b1;
    out_ready = 1'b1; sb.push_back({in_I, in_Q});
    tick();
    in_valid_I = 1'b0; in_valid_Q = 1'b0; out_ready = 1'b0;
    tick();
    chk("fullpop_fill", 64'(fill_level), 64'd16);
    chk("fullpop_overflow", 64'(overflow), 64'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 40; i++) if (sb.size() != 0) tick();
    chk("drain1_sb", 64'(sb.size()), 64'd0);
    chk("drain1_fill", 64'(fill_level), 64'd0);
    chk("drain1_valid", 64'(out_valid), 64'd0);

    // Desync: I, I, Q yields one pair with the newer I
    in_I = 32'h0000_000A; in_valid_I = 1'b1; tick(); in_valid_I = 1'b0; tick();
    in_I = 32'h0000_000B; in_valid_I = 1'b1; tick(); in_valid_I = 1'b0; tick();
    in_Q = 32'h0000_000C; in_valid_Q = 1'b1; sb.push_back({32'h0000_000B, 32'h0000_000C});
    tick(); in_valid_Q = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    chk("desync_set", 64'(desync), 64'd1);
    chk("desync_sb", 64'(sb.size()), 64'd0);
    clear_flags = 1'b1; tick(); clear_flags = 1'b0;
    chk("desync_clr", 64'(desync), 64'd0);

    // Backpressure and pointer wrap over 40 split-strobe pairs
    for (int k = 0; k < 40; k++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      in_I = 32'h0000_1000 + 32'(k); in_valid_I = 1'b1; tick();
      in_valid_I = 1'b0; out_ready = ($urandom_range(0, 3) != 0);
      in_Q = 32'h0000_2000 + 32'(k); in_valid_Q = 1'b1; sb.push_back({in_I, in_Q}); tick();
      in_valid_Q = 1'b0; out_ready = ($urandom_range(0, 3) != 0); tick();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 60; i++) if (sb.size() != 0) tick();
    chk("wrap_sb", 64'(sb.size()), 64'd0);
    chk("wrap_fill", 64'(fill_level), 64'd0);
    chk("wrap_overflow", 64'(overflow), 64'd0);

    // Disable with 5 stored pairs and a half pair pending
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      in_I = 32'hE000_0000 + 32'(k); in_Q = 32'hF000_0000 + 32'(k);
      in_valid_I = 1'b1; in_valid_Q = 1'b1; tick();
      in_valid_I = 1'b0; in_valid_Q = 1'b0; tick();
    end
    in_valid_I = 1'b1; tick(); in_valid_I = 1'b0; tick();
    in_valid_I = 1'b1; tick(); in_valid_I = 1'b0; tick();
    chk("dis_pre_fill", 64'(fill_level), 64'd5);
    chk("dis_pre_valid", 64'(out_valid), 64'd1);
    enabled = 1'b0; tick();
    sb.delete();
    chk("dis_valid", 64'(out_valid), 64'd0);
    chk("dis_fill", 64'(fill_level), 64'd0);
    chk("dis_data", {out_I, out_Q}, 64'd0);
    chk("dis_sticky", 64'(desync), 64'd1);
    in_valid_I = 1'b1; in_valid_Q = 1'b1; tick();
    enabled = 1'b1; tick(); tick(); tick();
    chk("reen_fill", 64'(fill_level), 64'd0);
    chk("reen_valid", 64'(out_valid), 64'd0);
    in_valid_I = 1'b0; in_valid_Q = 1'b0; tick();
    in_valid_Q = 1'b1; tick(); in_valid_Q = 1'b0; tick(); tick(); tick();
    chk("reen_fsm_idle", 64'(fill_level), 64'd0);

    // Reset in the middle of a burst
    in_valid_Q = 1'b1; tick(); in_valid_Q = 1'b0; tick();
    for (int k = 0; k < 3; k++) begin
      in_valid_I = 1'b1; in_valid_Q = 1'b1; tick();
      in_valid_I = 1'b0; in_valid_Q = 1'b0; tick();
    end
    chk("burst_valid", 64'(out_valid), 64'd1);
    in_valid_I = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    chk("mrst_valid", 64'(out_valid), 64'd0);
    chk("mrst_fill", 64'(fill_level), 64'd0);
    chk("mrst_data", {out_I, out_Q}, 64'd0);
    chk("mrst_flags", {62'd0, overflow, desync}, 64'd0);
    sb.delete();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
